// File: rtl/mux_scan_sequencer.sv
// Scanned drive for the three cascaded 8:1 analog mux banks: break-before-make
// parking, settling delay and one ADC conversion handshake per channel.
module mux_scan_sequencer #(
    parameter int NUM_CH         = 6,
    parameter int BREAK_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    input  logic       sample_ack,
    output logic [2:0] f1_sel,
    output logic [2:0] f2_sel,
    output logic [2:0] f3_sel,
    output logic [2:0] cur_ch,
    output logic       sample_req,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);

    localparam int MAX_BS = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
    localparam int MAX_P  = (MAX_BS > TIMEOUT_CYCLES) ? MAX_BS : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] BREAK_LAST   = CW'(BREAK_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_CH      = 3'(NUM_CH - 1);
    localparam logic [8:0]    PARK_CODE    = 9'd0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PARK    = 3'd1,
        S_SETTLE  = 3'd2,
        S_SAMPLE  = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    // Channel routing table, packed as {f1, f2, f3}.
    function automatic logic [8:0] route(input logic [2:0] ch);
        logic [8:0] r;
        case (ch)
            3'd0:    r = {3'd2, 3'd1, 3'd0};
            3'd1:    r = {3'd3, 3'd0, 3'd0};
            3'd2:    r = {3'd6, 3'd1, 3'd0};
            3'd3:    r = {3'd2, 3'd3, 3'd0};
            3'd4:    r = {3'd3, 3'd4, 3'd0};
            3'd5:    r = {3'd6, 3'd3, 3'd0};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    sel_q, sel_d;
    logic [2:0]    ch_q, ch_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          terr_q, terr_d;
    logic          cont_q, cont_d;
    logic          pend_q, pend_d;
    logic          stop_now;

    assign stop_now = pend_q | stop;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ch_d    = ch_q;
        req_d   = req_q;
        done_d  = 1'b0;
        terr_d  = terr_q;
        cont_d  = cont_q;
        pend_d  = pend_q;

        case (state_q)
            S_IDLE: begin
                sel_d = PARK_CODE;
                req_d = 1'b0;
                if (start && !stop) begin
                    state_d = S_PARK;
                    ch_d    = 3'd0;
                    cont_d  = continuous;
                    terr_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PARK: begin
                if (stop) begin
                    state_d = S_IDLE;
                    sel_d   = PARK_CODE;
                end else if (cnt_q == BREAK_LAST) begin
                    state_d = S_SETTLE;
                    sel_d   = route(ch_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    sel_d   = PARK_CODE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                    req_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                pend_d = stop_now;
                // Ack wins over a timeout landing on the same edge.
                if (sample_ack) begin
                    state_d = S_ADVANCE;
                    req_d   = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_ADVANCE;
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ADVANCE: begin
                sel_d = PARK_CODE;
                if (ch_q == LAST_CH) begin
                    done_d = 1'b1;
                    if (cont_q && !stop_now) begin
                        state_d = S_PARK;
                        ch_d    = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (stop_now) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PARK;
                    ch_d    = ch_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = PARK_CODE;
                req_d   = 1'b0;
            end
        endcase

        // Every state entry restarts the shared cycle counter.
        if (state_d != state_q) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end

        if (state_d == S_IDLE) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            sel_q   <= PARK_CODE;
            ch_q    <= 3'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            cont_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ch_q    <= ch_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            cont_q  <= cont_d;
            pend_q  <= pend_d;
        end
    end

    assign f1_sel      = sel_q[8:6];
    assign f2_sel      = sel_q[5:3];
    assign f3_sel      = sel_q[2:0];
    assign cur_ch      = ch_q;
    assign sample_req  = req_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequences the three cascaded 8:1 analog mux banks (F1 bottom, F2 middle, F3 top) through a fixed channel table.
- Per channel: parks the muxes (break-before-make), applies the routing, waits for analog settling, then handshakes one conversion with the downstream ADC capture logic.
- Replaces the static select drive with a scanned, ADC-synchronised drive. Supports single-frame and continuous scanning.

Parameters:
- NUM_CH, 6, channels in the scan frame (1..8); indices 0..NUM_CH-1.
- BREAK_CYCLES, 2, cycles the park code (0,0,0) is held before each new routing (>=1).
- SETTLE_CYCLES, 1000, cycles the routing is held before sample_req (>=1).
- TIMEOUT_CYCLES, 4096, maximum cycles sample_req waits for sample_ack (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a frame at channel 0; ignored when busy=1
- stop  in  1  abort request
- continuous  in  1  sampled with start; 1 = wrap and rescan forever
- sample_ack  in  1  ADC capture complete; one-cycle pulse expected
- f1_sel  out  3  F1 bank select {C,B,A}
- f2_sel  out  3  F2 bank select
- f3_sel  out  3  F3 bank select
- cur_ch  out  3  channel currently routed/being sampled
- sample_req  out  1  level; high while waiting for sample_ack
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last channel of a frame completes
- timeout_err  out  1  sticky; set on any sample timeout, cleared by an accepted start

Behaviour:
- Reset values (async, all outputs registered):
  - selects = 0/0/0, cur_ch = 0
  - sample_req, busy, frame_done, timeout_err = 0
  - state = IDLE, latched continuous = 0
- Routing table (f1, f2, f3):
  - ch0 = 2,1,0
  - ch1 = 3,0,0
  - ch2 = 6,1,0
  - ch3 = 2,3,0
  - ch4 = 3,4,0
  - ch5 = 6,3,0
  - ch6, ch7 = 0,0,0
- Park code is 0,0,0.
- States and transitions:
  - IDLE: selects at park. On start=1 and stop=0: cur_ch<=0, latch continuous, clear timeout_err, busy<=1, go to PARK.
  - PARK: selects park for exactly BREAK_CYCLES cycles, then load table[cur_ch] and go to SETTLE.
  - SETTLE: hold the routing for exactly SETTLE_CYCLES cycles, then set sample_req<=1 and go to SAMPLE.
  - SAMPLE: hold sample_req until sample_ack=1 or the wait counter reaches TIMEOUT_CYCLES.
    - Either exit: sample_req<=0, go to ADVANCE.
    - Timeout exit also sets timeout_err.
  - ADVANCE (1 cycle), at the end of a frame (cur_ch == NUM_CH-1):
    - Pulse frame_done.
    - If continuous was latched and stop is not pending: cur_ch<=0, go to PARK.
    - Otherwise: selects to park, busy<=0, go to IDLE.
  - ADVANCE (1 cycle), mid-frame: cur_ch<=cur_ch+1, go to PARK.
- Latency: with start captured on edge E, sample_req rises on edge E+BREAK_CYCLES+SETTLE_CYCLES.
  - Channel-to-channel period = BREAK + SETTLE + (ack wait) + 2 cycles.
- Stop handling:
  - stop in PARK or SETTLE: abort immediately. Next state IDLE, selects park, busy 0, no frame_done.
  - stop in SAMPLE: registered as pending. The current sample completes (ack or timeout), then ADVANCE goes to IDLE.
  - Pending stop is cleared on entering IDLE.
- start while busy: ignored. start and stop in the same IDLE cycle: stop wins, stay in IDLE.
- sample_ack outside SAMPLE is ignored. sample_ack on the same edge as timeout counts as ack; timeout_err is not set.
- Counters:
  - Width = clog2(max parameter)+1.
  - Cleared on every state entry.
  - Never wrap, because they compare for equality before incrementing.
- Reset mid-operation: immediate return to the reset values; sample_req drops asynchronously.

Test Plan:
- Test parameters: NUM_CH=6, BREAK=2, SETTLE=4, TIMEOUT=16. The ADC model acks 3 cycles after sample_req.
- Single frame: start pulse at edge 10 -> sample_req rises at edge 16 with f1/f2/f3=2/1/0, cur_ch=0.
  - Channels 0..5 follow the table in order, each preceded by 2 park cycles.
  - frame_done pulses once, then busy=0 and selects 0/0/0.
- Continuous: start with continuous=1 -> after ch5, cur_ch returns to 0 with frame_done each wrap.
  - stop raised during ch3 SAMPLE -> ch3 ack honoured, then IDLE, no further sample_req.
- Timeout: ADC silent on ch2 -> sample_req high exactly 16 cycles, timeout_err=1, ch3 proceeds.
  - A new start clears timeout_err.
- Abort in SETTLE: stop on the 2nd SETTLE cycle of ch1 -> next edge busy=0, selects 0/0/0, no frame_done, no sample_req.
- Corner events:
  - Ack coincident with the timeout edge -> timeout_err stays 0.
  - start asserted while busy -> no effect on cur_ch.
  - start+stop together in IDLE -> stays IDLE.
  - Async rst during SAMPLE -> sample_req drops before the next clk edge, all outputs at reset values.
